// File: rtl/sort_loader.sv
// Frame loader for an 8-input parallel sorter.
// Collects up to eight samples from a valid/ready stream into slots d0..d7. It pads unused
// slots on a short frame, pulses sort_en for one cycle, then freezes the slots for HOLD cycles
// before it accepts the next frame.
module sort_loader #(
   parameter int unsigned   DW   = 16,
   parameter int unsigned   HOLD = 4,
   parameter logic [DW-1:0] PAD  = {DW{1'b1}}
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          sort_en,
   output logic [DW-1:0] d0,
   output logic [DW-1:0] d1,
   output logic [DW-1:0] d2,
   output logic [DW-1:0] d3,
   output logic [DW-1:0] d4,
   output logic [DW-1:0] d5,
   output logic [DW-1:0] d6,
   output logic [DW-1:0] d7,
   output logic [3:0]    frame_len,
   output logic          busy,
   output logic [15:0]   frame_cnt
);

   // Width of the hold down-counter; must represent the value HOLD itself.
   localparam int unsigned CW = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      StFill,
      StLaunch,
      StHold
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            ready_q;
   logic [DW-1:0]   slot_q [8];
   logic [3:0]      len_q;
   logic            accept;
   logic            close;

   // ready_q keeps s_ready low during reset and until the first edge after release.
   assign s_ready = ready_q && (state_q == StFill);
   assign accept  = s_valid && s_ready;
   // An eighth sample closes the frame whether or not s_last is set.
   assign close   = accept && (s_last || (idx_q == 3'd7));

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
         idx_q   <= 3'd0;
         hold_q  <= '0;
         cnt_q   <= 16'd0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         ready_q <= 1'b1;
      end
   end

   // Next-state, write index, hold counter, frame counter and the launch pulse.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      sort_en = 1'b0;
      case (state_q)
         StFill: begin
            if (accept) begin
               idx_d = close ? 3'd0 : idx_q + 3'd1;
               if (close) begin
                  state_d = StLaunch;
               end
            end
         end
         StLaunch: begin
            sort_en = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            hold_d  = CW'(HOLD);
            state_d = StHold;
         end
         StHold: begin
            hold_d = hold_q - CW'(1);
            if (hold_q == CW'(1)) begin
               state_d = StFill;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   // Slot and frame-length storage; written only on an accepted sample or a close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            slot_q[i] <= '0;
         end
         len_q <= 4'd0;
      end else if (accept) begin
         slot_q[idx_q] <= s_data;
         if (close) begin
            // Slots above the closing index would otherwise carry the previous frame.
            for (int i = 0; i < 8; i++) begin
               if (3'(i) > idx_q) begin
                  slot_q[i] <= PAD;
               end
            end
            len_q <= {1'b0, idx_q} + 4'd1;
         end
      end
   end

   assign d0        = slot_q[0];
   assign d1        = slot_q[1];
   assign d2        = slot_q[2];
   assign d3        = slot_q[3];
   assign d4        = slot_q[4];
   assign d5        = slot_q[5];
   assign d6        = slot_q[6];
   assign d7        = slot_q[7];
   assign frame_len = len_q;
   assign busy      = (state_q != StFill);
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sort_loader.sv
// Bench for sort_loader.
// The driver builds each expected frame from the samples it has handed over and queues it.
// A monitor pops one queued frame per sort_en pulse and checks slots, length, timing, the hold
// window and the frame counter.
module tb_sort_loader;

   localparam int unsigned DW   = 16;
   localparam int unsigned HOLD = 4;
   localparam logic [15:0] PAD  = 16'hFFFF;

   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          sort_en;
   logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
   logic [3:0]    frame_len;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic [127:0]  d_all;

   sort_loader #(
      .DW   (DW),
      .HOLD (HOLD),
      .PAD  (PAD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .sort_en   (sort_en),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .d4        (d4),
      .d5        (d5),
      .d6        (d6),
      .d7        (d7),
      .frame_len (frame_len),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   assign d_all = {d7, d6, d5, d4, d3, d2, d1, d0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   len;
      logic [15:0]  cnt;
      int           launch;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] frame[$];
   logic [15:0] model_cnt;
   logic [15:0] full_v [8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // Expected frame: collected samples in order, PAD in every remaining slot.
   task automatic close_frame(input int launch);
      exp_t e;
      e.d = '0;
      for (int i = 0; i < 8; i++) begin
         e.d[16*i +: 16] = (i < frame.size()) ? frame[i] : PAD;
      end
      e.len     = 4'(frame.size());
      model_cnt = model_cnt + 16'd1;
      e.cnt     = model_cnt;
      e.launch  = launch;
      exp_q.push_back(e);
      frame.delete();
   endtask

   // Present one sample and hold it until accepted; s_valid is left high for back-to-back use.
   task automatic send(input logic [15:0] data, input logic last);
      int guard = 0;
      int launch;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = data;
      s_last  = last;
      while (!s_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         fail_now("send_timeout");
         s_valid = 1'b0;
         return;
      end
      launch = cyc + 1;
      @(posedge clk);
      frame.push_back(data);
      if (last || frame.size() == 8) begin
         close_frame(launch);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (!(s_ready && !busy && exp_q.size() == 0) && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (g >= 60) fail_now("wait_idle");
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_s_ready"}, 128'(s_ready), 128'(0));
      chk({tag, "_sort_en"}, 128'(sort_en), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_frame_len"}, 128'(frame_len), 128'(0));
      chk({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(0));
      chk({tag, "_slots"}, d_all, 128'(0));
   endtask

   task automatic release_rst(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({tag, "_ready_before_edge"}, 128'(s_ready), 128'(0));
      @(posedge clk);
      #1;
      chk({tag, "_ready_after_edge"}, 128'(s_ready), 128'(1));
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      #1;
      reset_checks(tag);
      frame.delete();
      model_cnt = 16'd0;
      repeat (2) begin
         @(negedge clk);
         chk({tag, "_no_sort_en"}, 128'(sort_en), 128'(0));
      end
      release_rst(tag);
   endtask

   // Monitor: one queued frame per launch, then the hold window must be frozen for 1+HOLD cycles.
   initial begin
      exp_t cur;
      int   gap;
      bit   armed;
      armed = 1'b0;
      gap   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            armed = 1'b0;
         end else begin
            if (armed) begin
               if (s_ready) begin
                  chk("ready_gap", 128'(gap), 128'(1 + HOLD));
                  armed = 1'b0;
               end else begin
                  gap++;
                  chk("hold_slots", d_all, cur.d);
                  chk("hold_len", 128'(frame_len), 128'(cur.len));
                  chk("hold_no_sort_en", 128'(sort_en), 128'(0));
                  chk("hold_busy", 128'(busy), 128'(1));
                  if (gap == 2) chk("frame_cnt", 128'(frame_cnt), 128'(cur.cnt));
               end
            end
            if (sort_en) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_sort_en: got 1, expected 0 (cycle %0d)", cyc);
               end else begin
                  cur = exp_q.pop_front();
                  chk("launch_slots", d_all, cur.d);
                  chk("launch_len", 128'(frame_len), 128'(cur.len));
                  chk("launch_cycle", 128'(cyc), 128'(cur.launch));
                  chk("launch_busy", 128'(busy), 128'(1));
                  chk("launch_ready", 128'(s_ready), 128'(0));
                  armed = 1'b1;
                  gap   = 1;
               end
            end
         end
      end
   end

   initial begin
      int  len;
      logic lst;
      s_valid   = 1'b0;
      s_data    = '0;
      s_last    = 1'b0;
      rst_n     = 1'b0;
      model_cnt = 16'd0;
      full_v    = '{16'd8, 16'd3, 16'd5, 16'd1, 16'd7, 16'd2, 16'd6, 16'd4};

      repeat (2) @(negedge clk);
      reset_checks("por");
      release_rst("por");

      // Full frame, closed by the eighth sample.
      for (int i = 0; i < 8; i++) send(full_v[i], 1'b0);
      idle(1);
      wait_idle();

      // Short frame padded after three samples.
      send(16'd10, 1'b0);
      send(16'd20, 1'b0);
      send(16'd30, 1'b1);
      idle(1);
      wait_idle();

      // Single-sample frame, then a partial next frame must keep untouched slots.
      send(16'h0042, 1'b1);
      idle(1);
      wait_idle();
      send(16'h0011, 1'b0);
      send(16'h0022, 1'b0);
      idle(1);
      chk("retain_d0", 128'(d0), 128'(16'h0011));
      chk("retain_d1", 128'(d1), 128'(16'h0022));
      chk("retain_d2", 128'(d2), 128'(PAD));
      chk("retain_len", 128'(frame_len), 128'(1));
      send(16'h0033, 1'b1);
      idle(1);
      wait_idle();

      // Backpressure: s_valid never drops across three full frames.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 8; i++) send(16'($urandom), 1'b0);
      end
      idle(1);
      wait_idle();

      // s_last on the eighth sample behaves like a plain eighth sample.
      for (int i = 0; i < 8; i++) send(16'(100 + i), (i == 7));
      idle(1);
      wait_idle();

      // Random frames with random lengths and idle gaps.
      for (int f = 0; f < 15; f++) begin
         len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) begin
            lst = (i == len - 1) && ((len < 8) || ($urandom_range(0, 1) == 1));
            send(16'($urandom), lst);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
         end
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);
      wait_idle();

      // Reset after five samples: the partial frame is dropped.
      for (int i = 0; i < 5; i++) send(16'(200 + i), 1'b0);
      do_reset("mid_fill");
      for (int i = 0; i < 8; i++) send(16'(300 + i), 1'b0);
      idle(1);
      wait_idle();

      // Reset during the hold window.
      for (int i = 0; i < 8; i++) send(16'(400 + i), 1'b0);
      idle(1);
      repeat (2) @(negedge clk);
      chk("pre_reset_in_hold", 128'(busy), 128'(1));
      do_reset("mid_hold");
      for (int i = 0; i < 8; i++) send(16'(500 + i), 1'b0);
      idle(1);
      wait_idle();

      // Frame counter wrap from 16'hFFFF.
      force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
      model_cnt = 16'hFFFF;
      for (int i = 0; i < 4; i++) send(16'(600 + i), (i == 3));
      idle(1);
      wait_idle();
      chk("wrap_cnt", 128'(frame_cnt), 128'(0));

      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
